// File: rtl/sd_spi_card_responder_if.sv
// SD SPI-mode card link: host SPI pins plus byte-wide read port.
// slave = card side, master = host/memory side.
interface sd_spi_card_responder_if #(
  parameter int ADDR_W = 24
);
  logic              sd_clk;
  logic              sd_cs_n;
  logic              sd_mosi;
  logic              sd_miso;
  logic              sd_miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;

  modport slave (
    input  sd_clk, sd_cs_n, sd_mosi, mem_data,
    output sd_miso, sd_miso_oe, mem_addr, mem_rd
  );

  modport master (
    output sd_clk, sd_cs_n, sd_mosi, mem_data,
    input  sd_miso, sd_miso_oe, mem_addr, mem_rd
  );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SD card SPI-mode responder: decodes host commands on MOSI, answers
// R1/R3/R7 and 512-byte single-block reads fetched from a byte memory.
// Ports: clk, reset_n (sync, active-low), bus (slave: SPI pins and
// memory read port), card_ready (ACMD41 initialisation done).
module sd_spi_card_responder #(
  parameter int ADDR_W     = 24,
  parameter int SDHC       = 1,
  parameter int NCR_BYTES  = 1,
  parameter int INIT_POLLS = 2,
  parameter int NAC_BYTES  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sd_spi_card_responder_if.slave   bus,
  output logic                     card_ready
);

  typedef enum logic [2:0] {
    RX_CMD, NCR, RESP, NAC, DATA, CRC
  } state_t;

  localparam logic [31:0] OCR =
    (SDHC != 0) ? 32'hC0FF_8000 : 32'h80FF_8000;
  localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES - 1);
  localparam logic [9:0] NAC_LAST = 10'(NAC_BYTES);
  localparam logic [7:0] POLLS    = 8'(INIT_POLLS);

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic [2:0] sck_s;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_s  <= '0;
      cs_s   <= 2'b11;
      mosi_s <= 2'b11;
    end else begin
      sck_s  <= {sck_s[1:0], bus.sd_clk};
      cs_s   <= {cs_s[0], bus.sd_cs_n};
      mosi_s <= {mosi_s[0], bus.sd_mosi};
    end
  end

  logic sck_rise, sck_fall, cs, mosi;
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign cs       = cs_s[1];
  assign mosi     = mosi_s[1];

  state_t            state;
  logic [5:0]        rx_cnt;
  logic [37:0]       rx_sh;
  logic [2:0]        tx_bit;
  logic [7:0]        tx_sh;
  logic [9:0]        byte_cnt;
  logic [39:0]       resp;
  logic [2:0]        resp_last;
  logic              go_data;
  logic [ADDR_W-1:0] base;
  logic              idle, app;
  logic [7:0]        poll;
  logic              rd_pend;
  logic [7:0]        rd_buf;
  logic [15:0]       crc;

  // Decode of the captured command; applied on its 48th bit.
  logic [5:0]        idx;
  logic [31:0]       arg;
  logic [7:0]        r1_ok, r1_ill;
  logic [39:0]       c_resp;
  logic [2:0]        c_len;
  logic              c_data, c_idle, c_ready, c_app;
  logic [7:0]        c_poll;
  logic [ADDR_W-1:0] c_base;

  always_comb begin
    idx     = rx_sh[37:32];
    arg     = rx_sh[31:0];
    r1_ok   = {7'b0, idle};
    r1_ill  = {5'b0, 1'b1, 1'b0, idle};
    c_resp  = {r1_ill, 32'hFFFF_FFFF};
    c_len   = 3'd1;
    c_data  = 1'b0;
    c_idle  = idle;
    c_ready = card_ready;
    c_app   = (idx == 6'd55);
    c_poll  = poll;
    c_base  = (SDHC != 0) ? ADDR_W'({arg, 9'b0})
                          : ADDR_W'({arg[31:9], 9'b0});
    unique case (1'b1)
      idx == 6'd0: begin
        c_resp  = {8'h01, 32'hFFFF_FFFF};
        c_idle  = 1'b1;
        c_ready = 1'b0;
        c_poll  = '0;
      end
      idx == 6'd8: begin
        c_resp = {r1_ok, 24'h00_0001, arg[7:0]};
        c_len  = 3'd5;
      end
      idx == 6'd55: begin
        c_resp = {r1_ok, 32'hFFFF_FFFF};
      end
      idx == 6'd41 && app: begin
        if (poll < POLLS) begin
          c_resp = {8'h01, 32'hFFFF_FFFF};
          c_poll = poll + 8'd1;
        end else begin
          c_resp  = {8'h00, 32'hFFFF_FFFF};
          c_idle  = 1'b0;
          c_ready = 1'b1;
        end
      end
      idx == 6'd58: begin
        c_resp = {r1_ok, OCR};
        c_len  = 3'd5;
      end
      idx == 6'd17: begin
        if (idle) begin
          c_resp = {8'h05, 32'hFFFF_FFFF};
        end else begin
          c_resp = {8'h00, 32'hFFFF_FFFF};
          c_data = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.sd_miso    <= 1'b1;
      bus.sd_miso_oe <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.mem_addr   <= '0;
      card_ready     <= 1'b0;
      idle           <= 1'b1;
      app            <= 1'b0;
      poll           <= '0;
      state          <= RX_CMD;
      rx_cnt         <= '0;
      rx_sh          <= '0;
      tx_bit         <= '0;
      tx_sh          <= 8'hFF;
      byte_cnt       <= '0;
      resp           <= '1;
      resp_last      <= '0;
      go_data        <= 1'b0;
      base           <= '0;
      rd_pend        <= 1'b0;
      rd_buf         <= 8'hFF;
      crc            <= '0;
    end else begin
      bus.mem_rd <= 1'b0;
      rd_pend    <= bus.mem_rd;
      if (rd_pend) rd_buf <= bus.mem_data;
      if (cs) begin
        bus.sd_miso_oe <= 1'b0;
        bus.sd_miso    <= 1'b1;
        state          <= RX_CMD;
        rx_cnt         <= '0;
        tx_bit         <= '0;
        byte_cnt       <= '0;
      end else begin
        bus.sd_miso_oe <= 1'b1;
        if (state == RX_CMD) begin
          if (sck_fall) bus.sd_miso <= 1'b1;
          if (sck_rise) begin
            if (rx_cnt == 6'd0) begin
              if (!mosi) rx_cnt <= 6'd1;
            end else if (rx_cnt == 6'd1) begin
              if (mosi) rx_cnt <= 6'd2;
            end else if (rx_cnt != 6'd47) begin
              // bits 3..40 hold index and argument; CRC is skipped
              if (rx_cnt < 6'd40) rx_sh <= {rx_sh[36:0], mosi};
              rx_cnt <= rx_cnt + 6'd1;
            end else begin
              resp       <= c_resp;
              resp_last  <= c_len - 3'd1;
              go_data    <= c_data;
              base       <= c_base;
              idle       <= c_idle;
              card_ready <= c_ready;
              app        <= c_app;
              poll       <= c_poll;
              state      <= NCR;
              rx_cnt     <= '0;
              tx_bit     <= '0;
              tx_sh      <= 8'hFF;
              byte_cnt   <= '0;
            end
          end
        end else if (sck_fall) begin
          bus.sd_miso <= tx_sh[7];
          tx_sh       <= {tx_sh[6:0], 1'b1};
          tx_bit      <= tx_bit + 3'd1;
          // last bit of the byte goes out now; queue the next byte
          if (tx_bit == 3'd7) begin
            unique case (state)
              NCR: begin
                if (byte_cnt == NCR_LAST) begin
                  state    <= RESP;
                  byte_cnt <= '0;
                  tx_sh    <= resp[39:32];
                  resp     <= {resp[31:0], 8'hFF};
                end else begin
                  byte_cnt <= byte_cnt + 10'd1;
                  tx_sh    <= 8'hFF;
                end
              end
              RESP: begin
                if (byte_cnt == {7'b0, resp_last}) begin
                  byte_cnt <= '0;
                  if (go_data) begin
                    state        <= NAC;
                    tx_sh        <= (NAC_LAST == 10'd0) ? 8'hFE : 8'hFF;
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= base;
                  end else begin
                    state <= RX_CMD;
                  end
                end else begin
                  byte_cnt <= byte_cnt + 10'd1;
                  tx_sh    <= resp[39:32];
                  resp     <= {resp[31:0], 8'hFF};
                end
              end
              NAC: begin
                if (byte_cnt == NAC_LAST) begin
                  state        <= DATA;
                  byte_cnt     <= '0;
                  tx_sh        <= rd_buf;
                  crc          <= crc_upd(16'h0000, rd_buf);
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= bus.mem_addr + 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + 10'd1;
                  tx_sh    <= (byte_cnt + 10'd1 == NAC_LAST) ? 8'hFE
                                                            : 8'hFF;
                end
              end
              DATA: begin
                if (byte_cnt == 10'd511) begin
                  state    <= CRC;
                  byte_cnt <= '0;
                  tx_sh    <= crc[15:8];
                end else begin
                  byte_cnt <= byte_cnt + 10'd1;
                  tx_sh    <= rd_buf;
                  crc      <= crc_upd(crc, rd_buf);
                  // prefetch one byte ahead; byte 511 was the last
                  if (byte_cnt != 10'd510) begin
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= bus.mem_addr + 1'b1;
                  end
                end
              end
              CRC: begin
                if (byte_cnt == 10'd0) begin
                  byte_cnt <= 10'd1;
                  tx_sh    <= crc[7:0];
                end else begin
                  state    <= RX_CMD;
                  byte_cnt <= '0;
                end
              end
              default: state <= RX_CMD;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: a host task drives SPI
// mode 0 byte transfers; response tables plus block-read sequences.
module tb_sd_spi_card_responder;

  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic card_ready;

  sd_spi_card_responder_if #(.ADDR_W(24)) bus();

  sd_spi_card_responder #(
    .ADDR_W(24), .SDHC(1), .NCR_BYTES(1),
    .INIT_POLLS(2), .NAC_BYTES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .card_ready (card_ready)
  );

  always #5 clk = ~clk;

  logic        log_en = 1'b0;
  logic [23:0] rd_log[$];

  initial bus.mem_data = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_data <= bus.mem_addr[7:0] ^ bus.mem_addr[15:8];
      if (log_en) rd_log.push_back(bus.mem_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.sd_mosi = tx[i];
      #HALF;
      bus.sd_clk = 1'b1;
      rx[i] = bus.sd_miso;
      #HALF;
      bus.sd_clk = 1'b0;
    end
  endtask

  typedef struct {
    logic [47:0] cmd;
    int          n;
    logic [63:0] exp;
    logic        rdy;
  } vec_t;

  vec_t vt[19];

  task automatic send_cmd(input logic [47:0] cmd);
    logic [7:0] rx;
    for (int k = 0; k < 6; k++) xfer(cmd[47-8*k -: 8], rx);
  endtask

  task automatic run_vec(input int i);
    logic [63:0] got;
    logic [7:0]  rx;
    got = '0;
    send_cmd(vt[i].cmd);
    for (int k = 0; k < vt[i].n; k++) begin
      xfer(8'hFF, rx);
      got[63-8*k -: 8] = rx;
    end
    chk($sformatf("vec%0d_resp", i), got, vt[i].exp);
    chk($sformatf("vec%0d_ready", i),
        {63'b0, card_ready}, {63'b0, vt[i].rdy});
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [15:0] ref_crc(input logic [23:0] b);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      d = exp_byte(b + 24'(i));
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ d[j];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, {63'b0, bus.sd_miso}, 64'd1);
    chk({tag, "_oe"}, {63'b0, bus.sd_miso_oe}, 64'd0);
    chk({tag, "_mem_rd"}, {63'b0, bus.mem_rd}, 64'd0);
    chk({tag, "_mem_addr"}, {40'b0, bus.mem_addr}, 64'd0);
    chk({tag, "_ready"}, {63'b0, card_ready}, 64'd0);
  endtask

  localparam logic [47:0] C0   = 48'h40_0000_0000_95;
  localparam logic [47:0] C8   = 48'h48_0000_01AA_87;
  localparam logic [47:0] C55  = 48'h77_0000_0000_65;
  localparam logic [47:0] C41  = 48'h69_4000_0000_77;
  localparam logic [47:0] C58  = 48'h7A_0000_0000_FD;
  localparam logic [47:0] C5   = 48'h45_0000_0000_01;
  localparam logic [47:0] C17i = 48'h51_0000_0003_FF;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rx;
    logic [39:0] hdr;
    logic [15:0] crc_got;
    int          mism;
    int          gaps;

    vt[0]  = '{C0,   2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[1]  = '{C8,   6, 64'hFF01_0000_01AA_0000, 1'b0};
    vt[2]  = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[3]  = '{C41,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[4]  = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[5]  = '{C41,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[6]  = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[7]  = '{C41,  2, 64'hFF00_0000_0000_0000, 1'b1};
    vt[8]  = '{C58,  6, 64'hFF00_C0FF_8000_0000, 1'b1};
    vt[9]  = '{C0,   2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[10] = '{C17i, 5, 64'hFF05_FFFF_FF00_0000, 1'b0};
    vt[11] = '{C5,   2, 64'hFF05_0000_0000_0000, 1'b0};
    vt[12] = '{C41,  2, 64'hFF05_0000_0000_0000, 1'b0};
    vt[13] = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[14] = '{C41,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[15] = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[16] = '{C41,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[17] = '{C55,  2, 64'hFF01_0000_0000_0000, 1'b0};
    vt[18] = '{C41,  2, 64'hFF00_0000_0000_0000, 1'b1};

    bus.sd_clk  = 1'b0;
    bus.sd_cs_n = 1'b1;
    bus.sd_mosi = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_outputs("reset0");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.sd_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("oe_cs_low", {63'b0, bus.sd_miso_oe}, 64'd1);

    for (int i = 0; i <= 8; i++) run_vec(i);

    // single-block read, SDHC block 3 -> bytes 0x600..0x7FF
    rd_log.delete();
    log_en = 1'b1;
    send_cmd(48'h51_0000_0003_55);
    hdr = '0;
    for (int k = 0; k < 5; k++) begin
      xfer(8'hFF, rx);
      hdr[39-8*k -: 8] = rx;
    end
    chk("rd_header", {24'b0, hdr}, 64'h00FF_00FF_FFFE);
    mism = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, rx);
      if (rx !== exp_byte(24'h600 + 24'(i))) mism++;
    end
    chk("rd_data_mismatches", 64'(mism), 64'd0);
    xfer(8'hFF, rx);
    crc_got[15:8] = rx;
    xfer(8'hFF, rx);
    crc_got[7:0] = rx;
    chk("rd_crc16", {48'b0, crc_got}, {48'b0, ref_crc(24'h600)});
    log_en = 1'b0;
    chk("rd_count", 64'(rd_log.size()), 64'd512);
    if (rd_log.size() > 0)
      chk("rd_first_addr", {40'b0, rd_log[0]}, 64'h600);
    gaps = 0;
    for (int i = 1; i < rd_log.size(); i++)
      if (rd_log[i] !== rd_log[i-1] + 24'd1) gaps++;
    chk("rd_addr_order", 64'(gaps), 64'd0);
    xfer(8'hFF, rx);
    chk("idle_after_crc", {56'b0, rx}, 64'hFF);

    for (int i = 9; i <= 18; i++) run_vec(i);

    // abort in the middle of a block
    send_cmd(48'h51_0000_0001_55);
    hdr = '0;
    for (int k = 0; k < 5; k++) begin
      xfer(8'hFF, rx);
      hdr[39-8*k -: 8] = rx;
    end
    chk("abort_header", {24'b0, hdr}, 64'h00FF_00FF_FFFE);
    for (int i = 0; i < 100; i++) xfer(8'hFF, rx);
    @(negedge clk);
    bus.sd_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_oe", {63'b0, bus.sd_miso_oe}, 64'd0);
    chk("abort_miso", {63'b0, bus.sd_miso}, 64'd1);
    repeat (20) @(negedge clk);
    bus.sd_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    run_vec(8);

    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset1");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_card_responder.md
Name: sd_spi_card_responder

Overview:
- Card-side responder for the SD SPI-mode link. It is the other end of the SD host interface that the processor system drives on sd_clk, sd_cmd, sd_d.
- Decodes host commands on MOSI (sd_cmd) and answers on MISO (sd_d[0]) with R1/R3/R7 responses and 512-byte single-block reads.
- Read data is fetched from an external byte-wide memory port.
- Used in simulation and hardware-in-loop benches in place of a tied-off sd_d[0], so the boot loader can be exercised end to end.

Parameters:
- ADDR_W, 24, byte address width of the memory port (max 2^(ADDR_W-9) blocks).
- SDHC, 1, 1: block addressing and OCR CCS=1; 0: byte addressing (CMD17 arg used as byte address, low 9 bits ignored).
- NCR_BYTES, 1, number of 0xFF bytes between the command's last byte and the response's first byte (1..8).
- INIT_POLLS, 2, number of ACMD41 calls answered 0x01 before the card reports ready.
- NAC_BYTES, 2, number of 0xFF bytes between the R1 of CMD17 and the 0xFE start token.

Ports:
- clk  in  1  system clock; must be at least 4x the sd_clk frequency.
- reset_n  in  1  synchronous reset, active-low.
- sd_clk  in  1  SPI SCK from host, asynchronous to clk.
- sd_cs_n  in  1  chip select (sd_d[3]), active-low.
- sd_mosi  in  1  host data (sd_cmd).
- sd_miso  out  1  card data (sd_d[0]).
- sd_miso_oe  out  1  MISO output enable; the top-level tri-states sd_d[0] when low.
- mem_addr  out  ADDR_W  byte address of the read.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  read data, valid exactly 1 clk after mem_rd.
- card_ready  out  1  high once ACMD41 has completed initialisation.

Behaviour:
- Input sync: sd_clk, sd_cs_n and sd_mosi each pass through a 2-FF synchroniser. SCK rise = sync 0->1 transition; SCK fall = 1->0.
- SPI mode 0: MOSI is sampled on SCK rise, MSB first. MISO is updated on SCK fall. The first bit of each byte is presented when that byte is loaded.
- Reset values: sd_miso=1, sd_miso_oe=0, mem_rd=0, mem_addr=0, card_ready=0, idle flag=1, app flag=0, poll counter=0, FSM=RX_CMD, bit/byte counters=0.
- sd_cs_n high (synced): sd_miso_oe=0, sd_miso=1, FSM forced to RX_CMD, counters cleared. Card state is kept: idle flag, card_ready, app flag. This abort has priority over every other event in the same cycle.
- sd_cs_n low: sd_miso_oe=1. MISO shifts 0xFF whenever no response byte is pending.
- RX_CMD:
  - Hunt bitwise for a 0 start bit followed by a 1.
  - Collect 48 bits: index[5:0], arg[31:0], crc7+end bit.
  - The CRC is not checked.
  - After bit 48 -> NCR.
- NCR: shift NCR_BYTES of 0xFF, then -> RESP.
- RESP: shift the response bytes below, then -> RX_CMD, or -> NAC for an accepted CMD17.
  - R1 = {0, 0, 0, 0, 0, illegal, 0, idle}.
  - CMD0: R1=0x01. Sets the idle flag, clears card_ready, app flag and poll counter.
  - CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: R1; sets the app flag.
  - ACMD41 (CMD41 with the app flag set):
    - While the poll counter < INIT_POLLS: R1=0x01, counter++.
    - Otherwise: R1=0x00, idle flag cleared, card_ready=1.
  - CMD58: R3 = R1, then OCR. OCR = 0xC0FF8000 if SDHC, else 0x80FF8000.
  - CMD17 while idle: R1=0x05, no data.
  - CMD17 when ready: R1=0x00, then -> NAC.
  - Any other index, or CMD41 without the app flag: R1 = 0x04 | idle.
  - The app flag clears after any command other than CMD55.
- NAC: NAC_BYTES of 0xFF, then the token 0xFE -> DATA.
- DATA:
  - base = SDHC ? arg<<9 : {arg[ADDR_W-1:9], 9'b0}, truncated to ADDR_W.
  - For byte i (0..511): mem_addr = base+i.
  - mem_rd pulses during the previous byte's transfer, at least 2 clk before that byte is needed.
  - mem_data is captured into the tx shift byte. CRC16 is updated.
  - After byte 511 -> CRC.
- CRC: send CRC16-CCITT (polynomial 0x1021, init 0x0000, MSB first, over the 512 data bytes) as high byte then low byte, then -> RX_CMD.
- The host clocking MOSI during a response is ignored.
- Address overflow past 2^ADDR_W wraps modulo.

Test Plan:
- CMD0 (40 00 00 00 00 95), NCR_BYTES=1 -> MISO reads FF, 01; card_ready=0.
- CMD8 arg 0x000001AA -> FF, 01 00 00 01 AA.
- Repeat CMD55+ACMD41 with INIT_POLLS=2 -> ACMD41 R1 sequence 01, 01, 00; card_ready rises after the third; then CMD58 -> 00 C0 FF 80 00.
- Memory model returns mem_data = mem_addr[7:0]^mem_addr[15:8]; CMD17 arg 3 (SDHC=1):
  - MISO -> FF, 00, FF, FF, FE, then 512 bytes.
  - mem_addr spans 0x600..0x7FF in order.
  - The two CRC bytes match the reference CRC16.
- CMD17 issued right after CMD0 -> R1=0x05, no FE token; unknown CMD5 -> R1=0x05; CMD41 without CMD55 -> 0x05.
- Deassert sd_cs_n after 100 data bytes:
  - sd_miso_oe low within 3 clk.
  - After reassert, CMD58 answers 00 C0 FF 80 00, since card_ready is kept.
  - reset_n low for 1 clk -> all outputs back to their reset values.
